aes128_encipher_core: RTL and testbench

- Iterative AES-128 encryption engine, ECB single-block (FIPS-197).
- Takes a 128-bit cipher key and a 128-bit plaintext block and produces the ciphertext after 10 rounds.
- Expands round keys on the fly, so no external key schedule is needed.
- All SubBytes/SubWord lookups go through one shared, external, combinational 32-bit S-box (aes_sbox: four parallel byte S-boxes, sboxw in, new_sboxw out), instantiated next to this block in the datapath.

---
 rtl/aes128_encipher_core.sv | 180 ++++++++++++++++++
 tb/tb_aes128_encipher_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encipher_core.sv
// Iterative AES-128 encryption core (single 128-bit block).
// One round takes six cycles: KEY expands the next round key, SUB pushes the
// four state words through the shared external S-box, and MIX applies
// ShiftRows, MixColumns and AddRoundKey. The last round skips MixColumns.
module aes128_encipher_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic         ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEY,
    ST_SUB,
    ST_MIX
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] ct_q, ct_d;
  logic         ready_q, ready_d;

  // GF(2^8) multiply by x, reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of MixColumns with the circulant [02 03 01 01] matrix.
  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r (byte r of every column word) rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_word(s[127:96]), mix_word(s[95:64]),
            mix_word(s[63:32]), mix_word(s[31:0])};
  endfunction

  // Round-key expansion terms; only meaningful while in KEY, where the
  // S-box is looking at RotWord(w3).
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] keyT, w0n, w1n, w2n, w3n;
  assign {w0, w1, w2, w3} = rk_q;
  assign keyT = new_sboxw ^ {rcon_q, 24'h0};
  assign w0n  = w0 ^ keyT;
  assign w1n  = w1 ^ w0n;
  assign w2n  = w2 ^ w1n;
  assign w3n  = w3 ^ w2n;

  // Round tail: ShiftRows, optional MixColumns, AddRoundKey.
  logic [127:0] shifted, mixed, roundOut;
  assign shifted  = shift_rows(state_q);
  assign mixed    = mix_columns(shifted);
  assign roundOut = ((round_q == 4'd10) ? shifted : mixed) ^ rk_q;

  // S-box input selection, driven only from registers so the external
  // S-box path cannot close a combinational loop.
  always_comb begin
    sboxw = 32'h0;
    case (fsm_q)
      ST_KEY: sboxw = {w3[23:0], w3[31:24]};
      ST_SUB: begin
        case (idx_q)
          2'd0:    sboxw = state_q[127:96];
          2'd1:    sboxw = state_q[95:64];
          2'd2:    sboxw = state_q[63:32];
          default: sboxw = state_q[31:0];
        endcase
      end
      default: sboxw = 32'h0;
    endcase
  end

  // Next-state and datapath update for the round sequencer.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    ct_d    = ct_q;
    ready_d = ready_q;
    case (fsm_q)
      ST_IDLE: begin
        if (init) begin
          rk_d    = key;
          state_d = plaintext ^ key;
          round_d = 4'd1;
          rcon_d  = 8'h01;
          ready_d = 1'b0;
          fsm_d   = ST_KEY;
        end
      end
      ST_KEY: begin
        rk_d   = {w0n, w1n, w2n, w3n};
        rcon_d = xtime(rcon_q);
        idx_d  = 2'd0;
        fsm_d  = ST_SUB;
      end
      ST_SUB: begin
        case (idx_q)
          2'd0:    state_d[127:96] = new_sboxw;
          2'd1:    state_d[95:64]  = new_sboxw;
          2'd2:    state_d[63:32]  = new_sboxw;
          default: state_d[31:0]   = new_sboxw;
        endcase
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          fsm_d = ST_MIX;
        end
      end
      ST_MIX: begin
        state_d = roundOut;
        if (round_q == 4'd10) begin
          ct_d    = roundOut;
          ready_d = 1'b1;
          fsm_d   = ST_IDLE;
        end else begin
          round_d = round_q + 4'd1;
          fsm_d   = ST_KEY;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset back to an idle, cleared core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rk_q    <= '0;
      round_q <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
      ct_q    <= '0;
      ready_q <= 1'b1;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      ct_q    <= ct_d;
      ready_q <= ready_d;
    end
  end

  assign ciphertext = ct_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_aes128_encipher_core.sv
// Scoreboard bench for aes128_encipher_core. The external S-box is modelled
// here from its mathematical definition (GF inverse plus affine map), and
// expected ciphertexts come from a byte-array AES model or known vectors.
module tb_aes128_encipher_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic [127:0] ciphertext;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic         ready;

  // Ready is seen high after the 60th edge following the init edge,
  // i.e. in the 61st cycle counting the init cycle as the first.
  localparam int LATENCY = 60;

  localparam logic [127:0] V1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2P = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2C = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V3C = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] ct;
    int           start;
  } exp_t;

  exp_t         expQ[$];
  int           checks = 0;
  int           errors = 0;
  int           cycleCnt = 0;
  logic [7:0]   sboxTab [256];

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  assign new_sboxw = {sboxTab[sboxw[31:24]], sboxTab[sboxw[23:16]],
                      sboxTab[sboxw[15:8]],  sboxTab[sboxw[7:0]]};

  aes128_encipher_core dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .key        (key),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .sboxw      (sboxw),
    .new_sboxw  (new_sboxw),
    .ready      (ready)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box: multiplicative inverse in GF(2^8) followed by the AES affine map.
  task automatic buildSbox();
    logic [7:0] inv, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (xb != 8'h00 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Reference AES-128: full key schedule up front, then ten rounds on a byte array.
  function automatic logic [127:0] refEncrypt(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   w [176];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, x;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127 - 8 * i -: 8];
      s[i] = p[127 - 8 * i -: 8] ^ w[i];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4 * (i - 1) + j];
      if (i % 4 == 0) begin
        x      = tmp[0];
        tmp[0] = sboxTab[tmp[1]] ^ rc;
        tmp[1] = sboxTab[tmp[2]];
        tmp[2] = sboxTab[tmp[3]];
        tmp[3] = sboxTab[x];
        rc     = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4 * i + j] = w[4 * (i - 4) + j] ^ tmp[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sboxTab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row + 4 * c] = s[row + 4 * ((c + row) % 4)];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          if (r < 10)
            s[row + 4 * c] = gmul(t[4 * c + row], 8'h02) ^ gmul(t[4 * c + (row + 1) % 4], 8'h03)
                           ^ t[4 * c + (row + 2) % 4] ^ t[4 * c + (row + 3) % 4];
          else
            s[row + 4 * c] = t[row + 4 * c];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16 * r + i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Wait for idle, issue one request and queue its expected result.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] p,
                               input logic [127:0] expCt, input int hold);
    int   waited;
    exp_t rec;
    waited = 0;
    @(negedge clk);
    while (!ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      failNow("ready before start");
      return;
    end
    key = k; plaintext = p; init = 1'b1;
    @(posedge clk); #1;
    rec.ct = expCt; rec.start = cycleCnt;
    expQ.push_back(rec);
    checkOutput("ready drop after init", {127'b0, ready}, 128'd0);
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      failNow("completion wait");
      expQ.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: on every rising ready, pop and compare result and latency;
  // while busy, the ciphertext must still hold the last completed result.
  initial begin : monitor
    logic         prevReady;
    logic [127:0] heldCt;
    exp_t         rec;
    prevReady = 1'b1;
    heldCt    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        expQ.delete();
        heldCt = '0;
      end else if (ready && !prevReady) begin
        if (expQ.size() == 0) begin
          failNow("unexpected completion");
        end else begin
          rec = expQ.pop_front();
          checkOutput("ciphertext", ciphertext, rec.ct);
          checkOutput("latency", 128'(cycleCnt - rec.start), 128'(LATENCY));
          heldCt = rec.ct;
        end
      end else if (!ready) begin
        checkOutput("held ciphertext while busy", ciphertext, heldCt);
      end
      prevReady = ready;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed vectors, reset, busy, back-to-back and random traffic.
  initial begin : stimulus
    logic [127:0] rk, rp;
    int           start;
    exp_t         rec;
    reset = 1'b1; init = 1'b0; key = '0; plaintext = '0;
    buildSbox();
    repeat (3) @(negedge clk);
    checkOutput("reset ready", {127'b0, ready}, 128'd1);
    checkOutput("reset ciphertext", ciphertext, 128'd0);
    checkOutput("reset sboxw", {96'b0, sboxw}, 128'd0);
    reset = 1'b0;

    applyStimulus(V1K, V1P, V1C, 2);
    waitDrain();
    applyStimulus(V2K, V2P, V2C, 1);
    waitDrain();
    applyStimulus(128'd0, 128'd0, V3C, 1);
    waitDrain();

    // Reset in the middle of an encryption.
    applyStimulus(V1K, V1P, V1C, 1);
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("mid-op reset ready", {127'b0, ready}, 128'd1);
    checkOutput("mid-op reset ciphertext", ciphertext, 128'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    applyStimulus(V1K, V1P, V1C, 1);
    waitDrain();

    // A second init while busy must be ignored.
    applyStimulus(V1K, V1P, V1C, 1);
    repeat (9) @(negedge clk);
    key = V2K; plaintext = V2P; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    waitDrain();
    repeat (5) @(negedge clk);
    checkOutput("no queued restart", {127'b0, ready}, 128'd1);

    // Back-to-back: init held high across completion.
    @(negedge clk);
    key = V1K; plaintext = V1P; init = 1'b1;
    @(posedge clk); #1;
    start = cycleCnt;
    rec.ct = V1C; rec.start = start;
    expQ.push_back(rec);
    @(negedge clk);
    key = V2K; plaintext = V2P;
    repeat (LATENCY + 1) @(posedge clk);
    #1;
    rec.ct = V2C; rec.start = cycleCnt;
    expQ.push_back(rec);
    checkOutput("back-to-back restart edge", 128'(cycleCnt - start), 128'(LATENCY + 1));
    checkOutput("back-to-back ready drop", {127'b0, ready}, 128'd0);
    @(negedge clk);
    init = 1'b0;
    waitDrain();

    // Random keys and blocks against the reference model.
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(rk, rp, refEncrypt(rk, rp), int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
